lbg_train_ctrl: RTL and testbench
=================================

// Module: lbg_train_ctrl
// PURPOSE
//  Sequencer for LBG codebook training on the MFCC front end. Steps codebook level CNT_FOR 1..LEVELS
//  (codebook size 2^CNT_FOR) and runs split, distortion (D_update) and centroid-update engines by
//  pulse/finish handshakes. Iterates distortion+centroid until relative distortion drop < 2^-EPS_SHIFT
//  or MAX_ITER is reached, then splits again. Sits between top-level VQ control and the LBG datapath.
// PARAMETERS
//  D_W        45  width of distortion D1 / stored distortions
//  LEVELS     4   final CNT_FOR value (codebook size 16); legal range 1..4
//  MAX_ITER   16  max distortion passes per level; legal range 1..31
//  EPS_SHIFT  7   convergence threshold epsilon = 2^-EPS_SHIFT
// PORTS
//  clk          in   1    clock
//  rst_n        in   1    async active-low reset
//  START        in   1    pulse: begin training (accepted in IDLE only)
//  BUSY         out  1    high in any state other than IDLE
//  FINSH        out  1    1-cycle pulse: training complete
//  CNT_FOR      out  3    current level, drives split / D_update / centroid engines
//  ITER_CNT     out  5    distortion passes completed at current level
//  SPLIT_START  out  1    1-cycle pulse to split engine
//  SPLIT_FINSH  in   1    split engine done
//  DUPD_CLEAR   out  1    1-cycle pulse: clears D_update accumulator and counters
//  DUPD_START   out  1    1-cycle pulse: start distortion pass
//  DUPD_FINSH   in   1    distortion pass done
//  D1           in   D_W  accumulated distortion from D_update
//  CENT_START   out  1    1-cycle pulse to centroid-update engine
//  CENT_FINSH   in   1    centroid engine done
//  D_LAST       out  D_W  distortion sampled on last pass
// BEHAVIOUR
//  Reset: all outputs 0, CNT_FOR=0, internal D_prev=0, state IDLE. Async reset mid-op aborts at once.
//  FSM states: IDLE, SPLIT, CLR, DIST, SETTLE, CHECK, CENT, DONE.
//  IDLE  : START -> CNT_FOR<=1, ITER_CNT<=0, SPLIT_START=1 next cycle, -> SPLIT.
//  SPLIT : wait SPLIT_FINSH -> CLR.
//  CLR   : DUPD_CLEAR=1 for one cycle -> DIST; DUPD_START=1 on first DIST cycle only.
//  DIST  : wait DUPD_FINSH -> SETTLE.
//  SETTLE: 2 cycles (let final accumulation land in D1); on 2nd cycle D_LAST<=D1 -> CHECK.
//  CHECK : 1 cycle; ITER_CNT<=ITER_CNT+1. converged when any holds:
//          D_LAST==0; ITER_CNT+1==MAX_ITER; ITER_CNT!=0 and D_LAST>=D_prev;
//          ITER_CNT!=0 and ((D_prev-D_LAST)<<EPS_SHIFT) < D_LAST  (compare at D_W+EPS_SHIFT bits).
//          ITER_CNT==0 never converges by ratio (no D_prev yet).
//          not converged -> D_prev<=D_LAST, CENT_START pulse, -> CENT.
//          converged, CNT_FOR<LEVELS -> CNT_FOR+1, ITER_CNT<=0, D_prev<=0, SPLIT_START, -> SPLIT.
//          converged, CNT_FOR==LEVELS -> DONE.
//  CENT  : wait CENT_FINSH -> CLR.
//  DONE  : FINSH=1 one cycle -> IDLE; CNT_FOR, D_LAST hold until next START.
//  START while BUSY ignored. *_FINSH inputs outside their wait state ignored. FINSH in the same cycle
//  as the matching START pulse is not possible (START pulses are registered, min 1 cycle wait).
//  CNT_FOR stable throughout SPLIT..CENT of a level; changes only in CHECK.
//  Every *_START / DUPD_CLEAR is exactly one cycle, registered outputs.
// CONFIGURATION
//  LBG_CTRL_ABORT_EN defined: adds input ABORT (1 bit). ABORT high in any non-IDLE state -> next cycle
//   state IDLE, BUSY=0, DUPD_CLEAR=1 one cycle, no FINSH; CNT_FOR/ITER_CNT/D_LAST reset to 0.
//   ABORT in IDLE has no effect; ABORT and START together in IDLE: START wins.
//  Not defined: no ABORT port; only rst_n terminates training.
// TESTING
//  1 LEVELS=1, D1 seq 1000,990 -> 2 passes (990*128 diff 1280 >= 990 fails? diff=10,1280>=990 so
//    not converged) then 3rd pass D1=989 -> diff 1, 128<989 converged; FINSH, ITER_CNT=3, D_LAST=989.
//  2 LEVELS=4, each level converges on pass 2 (D1 constant 500) -> CNT_FOR 1,2,3,4; 4 SPLIT_START,
//    8 DUPD_START, 4 CENT_START, one FINSH.
//  3 MAX_ITER=3, D1 halves each pass 8000,4000,2000 -> stops after 3rd pass, ITER_CNT=3, 2 CENT_START.
//  4 D1=0 on first pass -> immediate convergence, no CENT_START at that level.
//  5 D1 rises 300->400 on pass 2 -> treated converged; D_LAST=400; START during BUSY ignored.
//  6 rst_n low mid-DIST -> all outputs 0 same cycle; with LBG_CTRL_ABORT_EN, ABORT in CENT ->
//    IDLE next cycle, DUPD_CLEAR pulse, no FINSH.

Source files
------------

// File: rtl/lbg_train_ctrl.sv
// LBG codebook training sequencer: steps codebook levels and drives the split, distortion and
// centroid engines through pulse/finish handshakes. Optional ABORT input with LBG_CTRL_ABORT_EN.
module lbg_train_ctrl #(
  parameter int D_W       = 45,
  parameter int LEVELS    = 4,
  parameter int MAX_ITER  = 16,
  parameter int EPS_SHIFT = 7
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef LBG_CTRL_ABORT_EN
  input  logic           ABORT,
`endif
  input  logic           START,
  output logic           BUSY,
  output logic           FINSH,
  output logic [2:0]     CNT_FOR,
  output logic [4:0]     ITER_CNT,
  output logic           SPLIT_START,
  input  logic           SPLIT_FINSH,
  output logic           DUPD_CLEAR,
  output logic           DUPD_START,
  input  logic           DUPD_FINSH,
  input  logic [D_W-1:0] D1,
  output logic           CENT_START,
  input  logic           CENT_FINSH,
  output logic [D_W-1:0] D_LAST
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPLIT, S_CLR, S_DIST, S_SETTLE, S_CHECK, S_CENT, S_DONE
  } state_t;

  state_t                   state;
  logic                     settle;
  logic [D_W-1:0]           d_prev;
  logic [D_W-1:0]           diff;
  logic [D_W+EPS_SHIFT-1:0] diff_sh;
  logic [5:0]               iter_next;
  logic                     converged;

  // Relative-drop test is done at D_W+EPS_SHIFT bits so the shifted difference cannot wrap.
  always_comb begin
    diff      = d_prev - D_LAST;
    diff_sh   = {{EPS_SHIFT{1'b0}}, diff} << EPS_SHIFT;
    iter_next = {1'b0, ITER_CNT} + 6'd1;
    converged = (D_LAST == '0) ||
                (iter_next == 6'(MAX_ITER)) ||
                ((ITER_CNT != '0) &&
                 ((D_LAST >= d_prev) || (diff_sh < {{EPS_SHIFT{1'b0}}, D_LAST})));
  end

  assign BUSY = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      settle      <= 1'b0;
      d_prev      <= '0;
      CNT_FOR     <= '0;
      ITER_CNT    <= '0;
      D_LAST      <= '0;
      FINSH       <= 1'b0;
      SPLIT_START <= 1'b0;
      DUPD_CLEAR  <= 1'b0;
      DUPD_START  <= 1'b0;
      CENT_START  <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; a state raises one only for the cycle it needs.
      FINSH       <= 1'b0;
      SPLIT_START <= 1'b0;
      DUPD_CLEAR  <= 1'b0;
      DUPD_START  <= 1'b0;
      CENT_START  <= 1'b0;
`ifdef LBG_CTRL_ABORT_EN
      if (ABORT && state != S_IDLE) begin
        state      <= S_IDLE;
        settle     <= 1'b0;
        d_prev     <= '0;
        CNT_FOR    <= '0;
        ITER_CNT   <= '0;
        D_LAST     <= '0;
        DUPD_CLEAR <= 1'b1;
      end else
`endif
      case (state)
        S_IDLE: if (START) begin
          CNT_FOR     <= 3'd1;
          ITER_CNT    <= '0;
          d_prev      <= '0;
          SPLIT_START <= 1'b1;
          state       <= S_SPLIT;
        end
        S_SPLIT: if (SPLIT_FINSH) begin
          DUPD_CLEAR <= 1'b1;
          state      <= S_CLR;
        end
        S_CLR: begin
          DUPD_START <= 1'b1;
          state      <= S_DIST;
        end
        S_DIST: if (DUPD_FINSH) begin
          settle <= 1'b0;
          state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle) begin
            D_LAST <= D1;
            settle <= 1'b0;
            state  <= S_CHECK;
          end else begin
            settle <= 1'b1;
          end
        end
        S_CHECK: begin
          ITER_CNT <= iter_next[4:0];
          if (!converged) begin
            d_prev     <= D_LAST;
            CENT_START <= 1'b1;
            state      <= S_CENT;
          end else if (CNT_FOR < 3'(LEVELS)) begin
            CNT_FOR     <= CNT_FOR + 3'd1;
            ITER_CNT    <= '0;
            d_prev      <= '0;
            SPLIT_START <= 1'b1;
            state       <= S_SPLIT;
          end else begin
            FINSH <= 1'b1;
            state <= S_DONE;
          end
        end
        S_CENT: if (CENT_FINSH) begin
          DUPD_CLEAR <= 1'b1;
          state      <= S_CLR;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbg_train_ctrl.sv
// Scoreboard bench for lbg_train_ctrl: per-pass D1 values carry hand-derived expected outcomes
// (event, level, pass count, sampled distortion) that are compared when the DUT raises a pulse.
module tb_lbg_train_ctrl;
  localparam int DW = 45;
  localparam int EV_NONE = 0, EV_SPLIT = 1, EV_CENT = 2, EV_DONE = 3;

  typedef struct {
    logic [DW-1:0] d1;
    int            kind;
    int            cnt;
    int            iter;
  } pass_t;

  typedef struct {
    int            kind;
    int            cnt;
    int            iter;
    logic [DW-1:0] d_last;
    bit            chk_d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          START, SPLIT_FINSH, DUPD_FINSH, CENT_FINSH;
  logic [DW-1:0] D1;
  logic          BUSY, FINSH, SPLIT_START, DUPD_CLEAR, DUPD_START, CENT_START;
  logic [2:0]    CNT_FOR;
  logic [4:0]    ITER_CNT;
  logic [DW-1:0] D_LAST;
`ifdef LBG_CTRL_ABORT_EN
  logic          ABORT;
`endif

  pass_t tbl[$];
  exp_t  sb[$];
  int    n_checks = 0, n_pass = 0;
  int    n_split = 0, n_clr = 0, n_dupd = 0, n_cent = 0, n_fin = 0, n_long = 0, n_order = 0;
  logic  pv_split = 0, pv_clr = 0, pv_dupd = 0, pv_cent = 0, pv_fin = 0;

  lbg_train_ctrl #(.D_W(DW), .LEVELS(4), .MAX_ITER(16), .EPS_SHIFT(7)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef LBG_CTRL_ABORT_EN
    .ABORT(ABORT),
`endif
    .START(START), .BUSY(BUSY), .FINSH(FINSH), .CNT_FOR(CNT_FOR), .ITER_CNT(ITER_CNT),
    .SPLIT_START(SPLIT_START), .SPLIT_FINSH(SPLIT_FINSH), .DUPD_CLEAR(DUPD_CLEAR),
    .DUPD_START(DUPD_START), .DUPD_FINSH(DUPD_FINSH), .D1(D1), .CENT_START(CENT_START),
    .CENT_FINSH(CENT_FINSH), .D_LAST(D_LAST)
  );

  always #5 clk = ~clk;

  // Pulse counters, width watchdog and clear-before-start ordering.
  always @(negedge clk) begin
    n_split <= n_split + int'(SPLIT_START);
    n_clr   <= n_clr + int'(DUPD_CLEAR);
    n_dupd  <= n_dupd + int'(DUPD_START);
    n_cent  <= n_cent + int'(CENT_START);
    n_fin   <= n_fin + int'(FINSH);
    if ((SPLIT_START && pv_split) || (DUPD_CLEAR && pv_clr) || (DUPD_START && pv_dupd) ||
        (CENT_START && pv_cent) || (FINSH && pv_fin))
      n_long <= n_long + 1;
    if (DUPD_START && !pv_clr) n_order <= n_order + 1;
    pv_split <= SPLIT_START; pv_clr <= DUPD_CLEAR; pv_dupd <= DUPD_START;
    pv_cent  <= CENT_START;  pv_fin <= FINSH;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  function automatic void add(input logic [DW-1:0] d, input int k, input int c, input int i);
    tbl.push_back(pass_t'{d, k, c, i});
  endfunction

  task automatic run(input bit poke, input bit rst_mid, input bit abort_cent,
                     input int e_split, input int e_dupd, input int e_cent);
    int  p = 0, cyc = 0, kind;
    int  t_split = -1, t_dupd = -1, t_cent = -1, t_fix = -1;
    int  s_split, s_clr, s_dupd, s_cent, s_fin;
    bit  done = 0;
    exp_t e;
    s_split = n_split; s_clr = n_clr; s_dupd = n_dupd; s_cent = n_cent; s_fin = n_fin;
    sb.push_back(exp_t'{EV_SPLIT, 1, 0, '0, 1'b0});
    @(negedge clk); START = 1'b1;
    while (!done) begin
      @(negedge clk); cyc++;
      START = 1'b0; SPLIT_FINSH = 1'b0; DUPD_FINSH = 1'b0; CENT_FINSH = 1'b0;
      if (cyc == t_fix) D1 = tbl[p-1].d1;
      if (SPLIT_START || CENT_START || FINSH) begin
        kind = SPLIT_START ? EV_SPLIT : (CENT_START ? EV_CENT : EV_DONE);
        if (sb.size() == 0) check("unexpected_event", kind, EV_NONE);
        else begin
          e = sb.pop_front();
          check("event_kind", kind, e.kind);
          check("cnt_for", CNT_FOR, e.cnt);
          check("iter_cnt", ITER_CNT, e.iter);
          if (e.chk_d) check("d_last", D_LAST, e.d_last);
        end
        if (SPLIT_START) t_split = cyc + 3;
        if (CENT_START) begin
`ifdef LBG_CTRL_ABORT_EN
          if (abort_cent) begin
            ABORT = 1'b1;
            @(negedge clk); ABORT = 1'b0;
            check("abort_busy", BUSY, 0);
            check("abort_clear", DUPD_CLEAR, 1);
            check("abort_finsh", FINSH, 0);
            check("abort_state", {CNT_FOR, ITER_CNT, D_LAST}, 0);
            done = 1;
          end
`endif
          t_cent = cyc + 2;
        end
        if (FINSH) done = 1;
      end
      if (DUPD_START && !done) begin
        if (rst_mid) begin
          check("pre_rst_busy", {BUSY, CNT_FOR}, {1'b1, 3'd1});
          #2 rst_n = 1'b0;
          #1 check("rst_outputs", {BUSY, FINSH, CNT_FOR, ITER_CNT, SPLIT_START, DUPD_CLEAR,
                                   DUPD_START, CENT_START, D_LAST}, 0);
          @(negedge clk); rst_n = 1'b1;
          done = 1;
        end else begin
          t_dupd = cyc + 4;
          if (poke) begin SPLIT_FINSH = 1'b1; CENT_FINSH = 1'b1; end
        end
      end
      if (cyc == t_split) SPLIT_FINSH = 1'b1;
      if (cyc == t_cent) CENT_FINSH = 1'b1;
      if (cyc == t_dupd && !done) begin
        if (p >= tbl.size()) begin
          check("table_overrun", p, tbl.size() - 1);
          done = 1;
        end else begin
          DUPD_FINSH = 1'b1;
          D1 = ~tbl[p].d1;  // must not be the sampled value; corrected two cycles later
          sb.push_back(exp_t'{tbl[p].kind, tbl[p].cnt, tbl[p].iter, tbl[p].d1, 1'b1});
          t_fix = cyc + 2;
          p++;
        end
      end
      if (poke && cyc == 6) START = 1'b1;
      if (cyc > 3000) begin check("timeout", cyc, 3000); done = 1; end
    end
    repeat (3) @(negedge clk);
    check("idle_busy", BUSY, 0);
    check("sb_empty", sb.size(), 0);
    if (!rst_mid && !abort_cent) begin
      check("passes_used", p, tbl.size());
      check("n_split_start", n_split - s_split, e_split);
      check("n_dupd_start", n_dupd - s_dupd, e_dupd);
      check("n_dupd_clear", n_clr - s_clr, e_dupd);
      check("n_cent_start", n_cent - s_cent, e_cent);
      check("n_finsh", n_fin - s_fin, 1);
    end
    sb.delete();
    tbl.delete();
  endtask

  initial begin
    rst_n = 1'b0; START = 1'b0; SPLIT_FINSH = 1'b0; DUPD_FINSH = 1'b0; CENT_FINSH = 1'b0;
    D1 = '0;
`ifdef LBG_CTRL_ABORT_EN
    ABORT = 1'b0;
`endif
    #12;
    check("reset_outputs", {BUSY, FINSH, SPLIT_START, DUPD_CLEAR, DUPD_START, CENT_START}, 0);
    check("reset_cnt_iter", {CNT_FOR, ITER_CNT}, 0);
    check("reset_d_last", D_LAST, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Epsilon boundary (equality is not converged), then the 1000/990/989 sequence at the last level.
    add(1290, EV_CENT, 1, 1); add(1280, EV_CENT, 1, 2); add(1279, EV_SPLIT, 2, 0);
    add(500, EV_CENT, 2, 1);  add(500, EV_SPLIT, 3, 0);
    add(500, EV_CENT, 3, 1);  add(500, EV_SPLIT, 4, 0);
    add(1000, EV_CENT, 4, 1); add(990, EV_CENT, 4, 2); add(989, EV_DONE, 4, 3);
    run(0, 0, 0, 4, 10, 6);

    // Reset while the distortion engine is running.
    run(0, 1, 0, 0, 0, 0);

    // Wide values whose shifted difference exceeds D_W bits; START and stray finishes ignored.
    add(45'd1 << 44, EV_CENT, 1, 1); add(45'd1 << 43, EV_CENT, 1, 2);
    add(45'd1 << 43, EV_SPLIT, 2, 0);
    add(500, EV_CENT, 2, 1); add(500, EV_SPLIT, 3, 0);
    add(500, EV_CENT, 3, 1); add(500, EV_SPLIT, 4, 0);
    add(500, EV_CENT, 4, 1); add(500, EV_DONE, 4, 2);
    run(1, 0, 0, 4, 9, 5);

    // Zero distortion, MAX_ITER cap with halving distortion, rising distortion, zero at last level.
    add(0, EV_SPLIT, 2, 0);
    for (int k = 1; k <= 16; k++)
      add(45'd1 << (31 - k), (k < 16) ? EV_CENT : EV_SPLIT, (k < 16) ? 2 : 3, (k < 16) ? k : 0);
    add(300, EV_CENT, 3, 1); add(400, EV_SPLIT, 4, 0);
    add(0, EV_DONE, 4, 1);
    run(0, 0, 0, 4, 20, 16);

`ifdef LBG_CTRL_ABORT_EN
    add(500, EV_CENT, 1, 1);
    run(0, 0, 1, 0, 0, 0);
`endif

    check("pulse_width", n_long, 0);
    check("clear_before_start", n_order, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
